// File: rtl/ones_run_pkg.sv
// Shared types and sizes for the ones-run scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ones_run_pkg;

    localparam int W     = 32;
    localparam int BYTES = 4;
    localparam int LEN_W = 6;
    localparam int POS_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Per-byte ones-string statistics.
    // t/h/m count 0..8.
    // p is the position of the longest run inside the byte; the lowest position wins a tie.
    typedef struct packed {
        logic [3:0] t;
        logic [3:0] h;
        logic [3:0] m;
        logic [2:0] p;
        logic       all;
    } byte_stats_t;

endpackage

// File: rtl/byte_run_stats.sv
// Ones-string analysis of one byte: trailing, leading and longest internal run.
// Latency: purely combinational.
// Backpressure: none.
module byte_run_stats
    import ones_run_pkg::*;
(
    input  logic [7:0]  i_byte,
    output byte_stats_t o_stats
);

    // Walk the bits once: trailing/leading counts plus longest run, lowest position on ties.
    always_comb begin
        logic [3:0] v_run;
        logic [3:0] v_start;
        logic       v_lead;
        logic       v_trail;
        o_stats = '0;
        v_run   = '0;
        v_start = '0;
        v_lead  = 1'b1;
        v_trail = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i_byte[i]) begin
                v_run = v_run + 4'd1;
                if (v_trail) o_stats.t = o_stats.t + 4'd1;
            end else begin
                v_run   = '0;
                v_trail = 1'b0;
            end
            if (v_run > o_stats.m) begin
                o_stats.m = v_run;
                v_start   = 4'(i) + 4'd1 - v_run;
                o_stats.p = v_start[2:0];
            end
        end
        for (int i = 7; i >= 0; i--) begin
            if (i_byte[i] && v_lead) o_stats.h = o_stats.h + 4'd1;
            else                     v_lead    = 1'b0;
        end
        o_stats.all = &i_byte;
    end

endmodule

// File: rtl/ones_run_scanner.sv
// Finds the longest run of 1s in a 32-bit word, one byte per clock, LSB byte first.
// Latency: result and done 4 cycles after the accepting edge; one word every 6 cycles.
// Backpressure: start is only honoured in IDLE; requests in SCAN/DONE are dropped, not queued.
module ones_run_scanner
    import ones_run_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [W-1:0]     A,
    output logic             busy,
    output logic             done,
    output logic [LEN_W-1:0] runlen,
    output logic [POS_W-1:0] runpos
);

    localparam int IDX_W = $clog2(BYTES);

    state_t             r_state;
    logic [IDX_W-1:0]   r_idx;
    logic [W-1:0]       r_op;
    logic [LEN_W-1:0]   r_cur_len;
    logic [POS_W-1:0]   r_cur_pos;
    logic [LEN_W-1:0]   r_best_len;
    logic [POS_W-1:0]   r_best_pos;
    logic [LEN_W-1:0]   r_runlen;
    logic [POS_W-1:0]   r_runpos;

    logic [7:0]         w_byte;
    byte_stats_t        w_st;
    logic [POS_W-1:0]   w_base;
    logic [LEN_W-1:0]   w_bnd_len;
    logic [POS_W-1:0]   w_bnd_pos;
    logic [POS_W-1:0]   w_int_pos;
    logic [LEN_W-1:0]   w_b1_len;
    logic [POS_W-1:0]   w_b1_pos;
    logic [LEN_W-1:0]   w_b2_len;
    logic [POS_W-1:0]   w_b2_pos;
    logic [LEN_W-1:0]   w_nxt_cur_len;
    logic [POS_W-1:0]   w_nxt_cur_pos;
    logic [LEN_W-1:0]   w_tail_start;

    assign w_byte = r_op[{r_idx, 3'b000} +: 8];
    assign w_base = {r_idx, 3'b000};

    byte_run_stats u_stats (
        .i_byte  (w_byte),
        .o_stats (w_st)
    );

    // Merge the current byte into the running state.
    // The boundary run is checked before the internal run, and only a strictly longer run replaces best.
    always_comb begin
        w_bnd_len = r_cur_len + {2'b00, w_st.t};
        w_bnd_pos = (r_cur_len != '0) ? r_cur_pos : w_base;
        w_int_pos = w_base + {2'b00, w_st.p};

        w_b1_len = r_best_len;
        w_b1_pos = r_best_pos;
        if (w_bnd_len > r_best_len) begin
            w_b1_len = w_bnd_len;
            w_b1_pos = w_bnd_pos;
        end

        w_b2_len = w_b1_len;
        w_b2_pos = w_b1_pos;
        if ({2'b00, w_st.m} > w_b1_len) begin
            w_b2_len = {2'b00, w_st.m};
            w_b2_pos = w_int_pos;
        end

        // The start of the run at the top of the byte can be 32 for byte 3 when h==0.
        // That value is never used, so truncating it to 5 bits is harmless.
        w_tail_start = {1'b0, w_base} + 6'd8 - {2'b00, w_st.h};
        if (w_st.all) begin
            w_nxt_cur_len = r_cur_len + 6'd8;
            w_nxt_cur_pos = r_cur_pos;
        end else begin
            w_nxt_cur_len = {2'b00, w_st.h};
            w_nxt_cur_pos = w_tail_start[POS_W-1:0];
        end
    end

    // FSM, operand capture, byte stepping and result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_op       <= '0;
            r_cur_len  <= '0;
            r_cur_pos  <= '0;
            r_best_len <= '0;
            r_best_pos <= '0;
            r_runlen   <= '0;
            r_runpos   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_op       <= A;
                        r_idx      <= '0;
                        r_cur_len  <= '0;
                        r_cur_pos  <= '0;
                        r_best_len <= '0;
                        r_best_pos <= '0;
                        r_state    <= SCAN;
                    end
                end
                SCAN: begin
                    r_cur_len  <= w_nxt_cur_len;
                    r_cur_pos  <= w_nxt_cur_pos;
                    r_best_len <= w_b2_len;
                    r_best_pos <= w_b2_pos;
                    r_idx      <= r_idx + 1'b1;
                    if (r_idx == IDX_W'(BYTES - 1)) begin
                        r_runlen <= w_b2_len;
                        r_runpos <= (w_b2_len == '0) ? '0 : w_b2_pos;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy   = (r_state == SCAN);
    assign done   = (r_state == DONE);
    assign runlen = r_runlen;
    assign runpos = r_runpos;

endmodule

// File: tb/tb_ones_run_scanner.sv
// Directed bench for ones_run_scanner: handshake timing, run results, tie rule, reset abort.
module tb_ones_run_scanner;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] A;
    logic        busy;
    logic        done;
    logic [5:0]  runlen;
    logic [4:0]  runpos;

    int n_checks;
    int n_fail;

    ones_run_scanner dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .A      (A),
        .busy   (busy),
        .done   (done),
        .runlen (runlen),
        .runpos (runpos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Launch a scan, then check busy and done on every cycle and the result at done.
    task automatic run_scan(input string tag, input logic [31:0] a,
                            input logic [5:0] exp_len, input logic [4:0] exp_pos);
        @(negedge clk);
        A     = a;
        start = 1'b1;
        @(negedge clk);                      // after E0
        start = 1'b0;
        A     = ~a;                          // must not disturb the scan in progress
        for (int c = 1; c <= 4; c++) begin
            chk({tag, " busy"}, 32'(busy), 32'd1);
            chk({tag, " done_lo"}, 32'(done), 32'd0);
            @(negedge clk);                  // after E1..E4
        end
        chk({tag, " busy_end"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " runlen"}, 32'(runlen), 32'(exp_len));
        chk({tag, " runpos"}, 32'(runpos), 32'(exp_pos));
        @(negedge clk);                      // after E5
        chk({tag, " done_pulse"}, 32'(done), 32'd0);
        chk({tag, " hold_len"}, 32'(runlen), 32'(exp_len));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        start    = 1'b0;
        A        = '0;
        #12;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst runlen", 32'(runlen), 32'd0);
        chk("rst runpos", 32'(runpos), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_scan("zero",     32'h0000_0000, 6'd0,  5'd0);
        run_scan("ones",     32'hFFFF_FFFF, 6'd32, 5'd0);
        run_scan("xbyte",    32'h0000_FF80, 6'd9,  5'd7);
        run_scan("tie",      32'h0F00_000F, 6'd4,  5'd0);
        run_scan("tie16",    32'hFF00_FFFF, 6'd16, 5'd0);
        run_scan("mid30",    32'h7FFF_FFFE, 6'd30, 5'd1);
        run_scan("top28",    32'hFFFF_FFF0, 6'd28, 5'd4);
        run_scan("msb",      32'h8000_0000, 6'd1,  5'd31);
        run_scan("pair",     32'h0001_8000, 6'd2,  5'd15);
        run_scan("inner",    32'h0000_0076, 6'd3,  5'd4);

        // A second start and a new A during SCAN are both ignored.
        @(negedge clk);
        A     = 32'h8000_0001;
        start = 1'b1;
        @(negedge clk);                      // after E0
        A     = 32'hFFFF_FFFF;
        for (int c = 1; c <= 3; c++) @(negedge clk);
        start = 1'b0;
        @(negedge clk);                      // after E4
        chk("ign done", 32'(done), 32'd1);
        chk("ign runlen", 32'(runlen), 32'd1);
        chk("ign runpos", 32'(runpos), 32'd0);
        @(negedge clk);
        @(negedge clk);                      // after E6, start was low
        chk("ign noqueue", 32'(busy), 32'd0);

        // start held high: a new scan begins on the first IDLE edge.
        @(negedge clk);
        A     = 32'h0000_0003;
        start = 1'b1;
        for (int c = 0; c < 5; c++) @(negedge clk);   // after E0..E4
        chk("hold done", 32'(done), 32'd1);
        chk("hold runlen", 32'(runlen), 32'd2);
        @(negedge clk);                      // after E5: IDLE
        chk("hold idle", 32'(busy), 32'd0);
        @(negedge clk);                      // after E6: rescanning
        chk("hold restart", 32'(busy), 32'd1);
        start = 1'b0;
        for (int c = 0; c < 6; c++) @(negedge clk);

        // Reset during the second SCAN cycle aborts and clears everything.
        A     = 32'h00FF_FF00;
        start = 1'b1;
        @(negedge clk);                      // after E0
        start = 1'b0;
        @(negedge clk);                      // after E1, second SCAN cycle
        chk("abort pre busy", 32'(busy), 32'd1);
        reset = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort runlen", 32'(runlen), 32'd0);
        chk("abort runpos", 32'(runpos), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_scan("after", 32'h00FF_FF00, 6'd16, 5'd8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ones_run_scanner.md
# ones_run_scanner

Sequential scanner that finds the longest string of consecutive 1s in a 32-bit ALU result and reports its length and starting bit index. It sits directly downstream of the ALU result register. It reuses byte-wide ones-string analysis and processes one byte per clock, so a full word takes four scan cycles. A start/busy/done handshake lets the test controller or ALU sequencer launch a scan and collect the result.

## Interface
- W, 32, operand width; fixed at 32 (4 bytes, scanned LSB byte first)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; the design is reset while reset==0
- start  input  1  launch request; sampled only in IDLE
- A  input  32  operand; captured on the accepting edge
- busy  output  1  high while scanning
- done  output  1  one-cycle pulse when a result is valid
- runlen  output  6  length of the longest run of 1s, 0..32
- runpos  output  5  bit index of the LSB of that run; 0 when runlen==0

## Operation
- States: IDLE, SCAN, DONE; enum lives in the package.
- IDLE + start==1 → latch A into opreg, clear running state, byte index idx=0, go to SCAN. start==0 → stay in IDLE.
- SCAN: each cycle consumes byte opreg[8*idx+7 : 8*idx] and increments idx.
  - After byte 3 (idx==3), write runlen/runpos and go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start is ignored in SCAN and DONE; no queuing.
- Running state:
  - cur_len/cur_pos describe the run of 1s ending at the highest bit processed so far.
  - best_len/best_pos hold the longest run found so far.
- Per byte, the sub-module supplies:
  - t = trailing-ones count from bit 0
  - h = leading-ones count from bit 7
  - m/p = longest internal run and its position
  - all = byte is 0xFF
- Merge per byte:
  - Boundary run = cur_len + t, starting at cur_pos if cur_len>0, else at the byte base.
  - Compare candidates in ascending-position order: boundary run, then internal run.
  - Replace best only when a candidate is strictly longer, so ties keep the lowest position.
  - Next cur: if all, then cur_len += 8; else cur_len = h, cur_pos = byte base + 8 − h.
- Width rules: cur_len and best_len are 6 bits and never exceed 32; position arithmetic is 5 bits (no overflow, since a run start is ≤31).
- runlen/runpos hold their value until the next completed scan overwrites them.

## Timing
- Reset values: busy=0, done=0, runlen=0, runpos=0, state=IDLE, idx=0, opreg=0.
- Reset is asynchronous: mid-scan assertion aborts immediately, discards partial results, and zeroes all outputs.
- Let edge E0 be the edge that samples start=1 in IDLE:
  - busy is high after E0 through E4.
  - Bytes 0..3 are processed on E1..E4.
  - runlen/runpos update on E4.
  - done is high between E4 and E5.
  - The next start can be accepted on E6 at the earliest (IDLE after E5).
- Latency: result visible 4 cycles after the accepting edge; throughput is one word per 6 cycles.
- A changing after E0 has no effect on the scan in progress.
- start held high continuously → a new scan begins on every IDLE edge.

## Structure
- Package ones_run_pkg holds:
  - W=32, BYTES=4, LEN_W=6, POS_W=5
  - state_t {IDLE, SCAN, DONE}
  - a struct for per-byte stats {t, h, m, p, all}
- Sub-module byte_run_stats: purely combinational; 8-bit input in, stats struct out; instantiated once and fed by the idx mux.
- The top-level ones_run_scanner holds the FSM, opreg, idx counter, and the running and best registers.

## Test plan
- A=0x0000_0000, start pulse → done on E4+, runlen=0, runpos=0; busy high exactly 4 cycles.
- A=0xFFFF_FFFF → runlen=32, runpos=0; checks the carry through all-ones bytes and the 6-bit width.
- A=0x0000_FF80 (ones on bits 7..15) → runlen=9, runpos=7; checks the byte-boundary merge.
- A=0x0F00_000F (runs of 4 at bits 0 and 24) → runlen=4, runpos=0; checks the tie rule.
- A=0x8000_0001, with start pulsed again and A changed to 0xFFFF_FFFF during SCAN → runlen=1, runpos=0; the second start is ignored and A is not resampled.
- A=0x00FF_FF00, reset driven to 0 during the second SCAN cycle → busy, done, runlen, runpos immediately 0. After release, a new start with A=0x00FF_FF00 → runlen=16, runpos=8.
